// File: rtl/alu_arbiter.sv
// Two-requester front end for the shared 8-bit combinational ALU: picks one
// request, registers its operands into the ALU, and returns result/flags on the winner's channel.
module alu_arb_rsp (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       capture,
    input  logic       ready,
    input  logic [7:0] result,
    input  logic [3:0] flags,
    output logic       valid,
    output logic [7:0] result_q,
    output logic [3:0] flags_q
);
    // Result/flags persist after hand-off; only a new capture overwrites them.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid    <= 1'b0;
            result_q <= '0;
            flags_q  <= '0;
        end else if (capture) begin
            valid    <= 1'b1;
            result_q <= result;
            flags_q  <= flags;
        end else if (valid && ready) begin
            valid    <= 1'b0;
        end
    end
endmodule

module alu_arbiter #(
    parameter bit RR_ENABLE = 1'b1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       req0_valid,
    output logic       req0_ready,
    input  logic [3:0] req0_op,
    input  logic [7:0] req0_a,
    input  logic [7:0] req0_b,
    input  logic       req1_valid,
    output logic       req1_ready,
    input  logic [3:0] req1_op,
    input  logic [7:0] req1_a,
    input  logic [7:0] req1_b,
    output logic [3:0] alu_operation,
    output logic [7:0] alu_operand1,
    output logic [7:0] alu_operand2,
    input  logic [7:0] alu_result,
    input  logic       alu_zero,
    input  logic       alu_overflow,
    input  logic       alu_carry,
    input  logic       alu_negative,
    output logic       rsp0_valid,
    input  logic       rsp0_ready,
    output logic [7:0] rsp0_result,
    output logic [3:0] rsp0_flags,
    output logic       rsp1_valid,
    input  logic       rsp1_ready,
    output logic [7:0] rsp1_result,
    output logic [3:0] rsp1_flags,
    output logic       busy
);
    localparam int NUM_REQ = 2;

    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

    typedef struct packed {
        logic [3:0] op;
        logic [7:0] a;
        logic [7:0] b;
    } alu_req_t;

    state_t state, state_nxt;

    logic [NUM_REQ-1:0]            req_valid;
    logic [NUM_REQ-1:0]            req_ready;
    alu_req_t [NUM_REQ-1:0]        req;
    logic [NUM_REQ-1:0]            rsp_ready;
    logic [NUM_REQ-1:0]            rsp_valid;
    logic [NUM_REQ-1:0][7:0]       rsp_result;
    logic [NUM_REQ-1:0][3:0]       rsp_flags;
    logic [NUM_REQ-1:0]            capture;

    alu_req_t latched;
    logic     grant;
    logic     owner;
    logic     last_grant;
    logic     accept;
    logic [3:0] alu_flags;

    assign req_valid = {req1_valid, req0_valid};
    assign req[0]    = {req0_op, req0_a, req0_b};
    assign req[1]    = {req1_op, req1_a, req1_b};
    assign rsp_ready = {rsp1_ready, rsp0_ready};
    assign alu_flags = {alu_zero, alu_overflow, alu_carry, alu_negative};

    // Lone requester wins; on contention RR picks whoever did not win last.
    always_comb begin
        grant = 1'b0;
        if (req_valid == 2'b10)
            grant = 1'b1;
        else if (req_valid == 2'b11 && RR_ENABLE)
            grant = ~last_grant;
    end

    assign accept = (state == IDLE) && (|req_valid);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (|req_valid)       state_nxt = EXEC;
            EXEC:                          state_nxt = RESP;
            RESP:    if (rsp_ready[owner]) state_nxt = IDLE;
            default:                       state_nxt = IDLE;
        endcase
    end

    always_comb begin
        req_ready = '0;
        if (accept)
            req_ready[grant] = 1'b1;
        busy = (state != IDLE);
    end

    assign req0_ready = req_ready[0];
    assign req1_ready = req_ready[1];

    // Operand latch drives the ALU directly and only moves on accept.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            latched    <= '0;
            owner      <= 1'b0;
            last_grant <= 1'b1;
        end else if (accept) begin
            latched <= req[grant];
            owner   <= grant;
            if (RR_ENABLE)
                last_grant <= grant;
        end
    end

    assign alu_operation = latched.op;
    assign alu_operand1  = latched.a;
    assign alu_operand2  = latched.b;

    for (genvar i = 0; i < NUM_REQ; i++) begin : g_rsp
        assign capture[i] = (state == EXEC) && (owner == 1'(i));

        alu_arb_rsp u_rsp (
            .clk      (clk),
            .rst_n    (rst_n),
            .capture  (capture[i]),
            .ready    (rsp_ready[i]),
            .result   (alu_result),
            .flags    (alu_flags),
            .valid    (rsp_valid[i]),
            .result_q (rsp_result[i]),
            .flags_q  (rsp_flags[i])
        );
    end

    assign rsp0_valid  = rsp_valid[0];
    assign rsp0_result = rsp_result[0];
    assign rsp0_flags  = rsp_flags[0];
    assign rsp1_valid  = rsp_valid[1];
    assign rsp1_result = rsp_result[1];
    assign rsp1_flags  = rsp_flags[1];
endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter: round-robin instance plus a fixed-priority
// instance, each wired to a small behavioural 8-bit ALU.
module tb_alu_arbiter;
    localparam logic [3:0] OP_ADD = 4'd0;
    localparam logic [3:0] OP_SUB = 4'd1;
    localparam logic [3:0] OP_AND = 4'd2;
    localparam logic [3:0] OP_OR  = 4'd3;
    localparam logic [3:0] OP_XOR = 4'd4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;

    // {result, Z, V, C, N}; SUB carry means "no borrow"
    function automatic logic [11:0] alu_model(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b);
        logic [8:0] s;
        logic [7:0] r;
        logic v, c;
        s = '0; r = '0; v = 1'b0; c = 1'b0;
        case (op)
            OP_ADD: begin
                s = {1'b0, a} + {1'b0, b};
                r = s[7:0];
                c = s[8];
                v = (a[7] == b[7]) && (r[7] != a[7]);
            end
            OP_SUB: begin
                r = a - b;
                c = (a >= b);
                v = (a[7] != b[7]) && (r[7] != a[7]);
            end
            OP_AND: r = a & b;
            OP_OR:  r = a | b;
            OP_XOR: r = a ^ b;
            default: r = '0;
        endcase
        return {r, (r == 8'h00), v, c, r[7]};
    endfunction

    // round-robin instance
    logic       req0_valid, req0_ready, req1_valid, req1_ready;
    logic [3:0] req0_op, req1_op, alu_operation;
    logic [7:0] req0_a, req0_b, req1_a, req1_b, alu_operand1, alu_operand2, alu_result;
    logic       alu_zero, alu_overflow, alu_carry, alu_negative;
    logic       rsp0_valid, rsp0_ready, rsp1_valid, rsp1_ready, busy;
    logic [7:0] rsp0_result, rsp1_result;
    logic [3:0] rsp0_flags, rsp1_flags;

    assign {alu_result, alu_zero, alu_overflow, alu_carry, alu_negative} =
        alu_model(alu_operation, alu_operand1, alu_operand2);

    alu_arbiter #(.RR_ENABLE(1'b1)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op(req0_op), .req0_a(req0_a), .req0_b(req0_b),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op(req1_op), .req1_a(req1_a), .req1_b(req1_b),
        .alu_operation(alu_operation), .alu_operand1(alu_operand1), .alu_operand2(alu_operand2),
        .alu_result(alu_result), .alu_zero(alu_zero), .alu_overflow(alu_overflow),
        .alu_carry(alu_carry), .alu_negative(alu_negative),
        .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready), .rsp0_result(rsp0_result), .rsp0_flags(rsp0_flags),
        .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready), .rsp1_result(rsp1_result), .rsp1_flags(rsp1_flags),
        .busy(busy)
    );

    // fixed-priority instance
    logic       f_req0_valid, f_req0_ready, f_req1_valid, f_req1_ready;
    logic [3:0] f_req0_op, f_req1_op, f_alu_operation;
    logic [7:0] f_req0_a, f_req0_b, f_req1_a, f_req1_b, f_alu_operand1, f_alu_operand2, f_alu_result;
    logic       f_alu_zero, f_alu_overflow, f_alu_carry, f_alu_negative;
    logic       f_rsp0_valid, f_rsp0_ready, f_rsp1_valid, f_rsp1_ready, f_busy;
    logic [7:0] f_rsp0_result, f_rsp1_result;
    logic [3:0] f_rsp0_flags, f_rsp1_flags;

    assign {f_alu_result, f_alu_zero, f_alu_overflow, f_alu_carry, f_alu_negative} =
        alu_model(f_alu_operation, f_alu_operand1, f_alu_operand2);

    alu_arbiter #(.RR_ENABLE(1'b0)) dut_fp (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(f_req0_valid), .req0_ready(f_req0_ready), .req0_op(f_req0_op), .req0_a(f_req0_a), .req0_b(f_req0_b),
        .req1_valid(f_req1_valid), .req1_ready(f_req1_ready), .req1_op(f_req1_op), .req1_a(f_req1_a), .req1_b(f_req1_b),
        .alu_operation(f_alu_operation), .alu_operand1(f_alu_operand1), .alu_operand2(f_alu_operand2),
        .alu_result(f_alu_result), .alu_zero(f_alu_zero), .alu_overflow(f_alu_overflow),
        .alu_carry(f_alu_carry), .alu_negative(f_alu_negative),
        .rsp0_valid(f_rsp0_valid), .rsp0_ready(f_rsp0_ready), .rsp0_result(f_rsp0_result), .rsp0_flags(f_rsp0_flags),
        .rsp1_valid(f_rsp1_valid), .rsp1_ready(f_rsp1_ready), .rsp1_result(f_rsp1_result), .rsp1_flags(f_rsp1_flags),
        .busy(f_busy)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        req0_valid = 1'b0; req1_valid = 1'b0;
        f_req0_valid = 1'b0; f_req1_valid = 1'b0;
        rsp0_ready = 1'b1; rsp1_ready = 1'b1;
        f_rsp0_ready = 1'b1; f_rsp1_ready = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        req0_valid = 1'b0; req1_valid = 1'b0;
        f_req0_valid = 1'b0; f_req1_valid = 1'b0;
        req0_op = 4'($urandom); req0_a = 8'($urandom); req0_b = 8'($urandom);
        req1_op = 4'($urandom); req1_a = 8'($urandom); req1_b = 8'($urandom);
        f_req0_op = 4'($urandom); f_req0_a = 8'($urandom); f_req0_b = 8'($urandom);
        f_req1_op = 4'($urandom); f_req1_a = 8'($urandom); f_req1_b = 8'($urandom);
        rsp0_ready = 1'($urandom); rsp1_ready = 1'($urandom);
        f_rsp0_ready = 1'($urandom); f_rsp1_ready = 1'($urandom);
        repeat (3) @(posedge clk);
        @(negedge clk);
        total++;
        if ({req0_ready, req1_ready, rsp0_valid, rsp1_valid, busy} !== 5'b0) begin
            bad++; $display("FAIL reset_ctrl got=%b want=00000", {req0_ready, req1_ready, rsp0_valid, rsp1_valid, busy});
        end
        total++;
        if ({rsp0_result, rsp0_flags, rsp1_result, rsp1_flags} !== 24'h0) begin
            bad++; $display("FAIL reset_rsp got=%h want=000000", {rsp0_result, rsp0_flags, rsp1_result, rsp1_flags});
        end
        total++;
        if ({alu_operation, alu_operand1, alu_operand2} !== 20'h0) begin
            bad++; $display("FAIL reset_alu got=%h want=00000", {alu_operation, alu_operand1, alu_operand2});
        end
        total++;
        if ({f_req0_ready, f_req1_ready, f_rsp0_valid, f_rsp1_valid, f_busy, f_rsp0_result, f_rsp1_result, f_alu_operand1} !== '0) begin
            bad++; $display("FAIL reset_fp got=%b want=0", {f_req0_ready, f_req1_ready, f_rsp0_valid, f_rsp1_valid, f_busy});
        end
        rst_n = 1'b1;
        rsp0_ready = 1'b1; rsp1_ready = 1'b1;
        f_rsp0_ready = 1'b1; f_rsp1_ready = 1'b1;
        step();
        @(negedge clk);
        total++;
        if (busy !== 1'b0) begin
            bad++; $display("FAIL reset_idle busy got=%b want=0", busy);
        end
        step();
    endtask

    task automatic test_single();
        req0_op = OP_ADD; req0_a = 8'h7F; req0_b = 8'h01; req0_valid = 1'b1;
        @(negedge clk);
        total++;
        if ({req0_ready, req1_ready} !== 2'b10) begin
            bad++; $display("FAIL single_ready got=%b want=10", {req0_ready, req1_ready});
        end
        step();
        req0_valid = 1'b0;
        @(negedge clk);
        total++;
        if ({busy, rsp0_valid} !== 2'b10) begin
            bad++; $display("FAIL single_exec busy,valid got=%b want=10", {busy, rsp0_valid});
        end
        step();
        @(negedge clk);
        total++;
        if (rsp0_valid !== 1'b1 || rsp0_result !== 8'h80) begin
            bad++; $display("FAIL single_result got=%b/%h want=1/80", rsp0_valid, rsp0_result);
        end
        total++;
        if (rsp0_flags !== 4'b0101) begin
            bad++; $display("FAIL single_flags got=%b want=0101", rsp0_flags);
        end
        total++;
        if (rsp1_valid !== 1'b0) begin
            bad++; $display("FAIL single_rsp1 got=%b want=0", rsp1_valid);
        end
        step();
        @(negedge clk);
        total++;
        if ({busy, rsp0_valid} !== 2'b00 || alu_operand1 !== 8'h7F) begin
            bad++; $display("FAIL single_done got=%b op1=%h want=00 op1=7f", {busy, rsp0_valid}, alu_operand1);
        end
        step();
    endtask

    task automatic test_contention_rr();
        apply_reset();
        req0_op = OP_SUB; req0_a = 8'h05; req0_b = 8'h05; req0_valid = 1'b1;
        req1_op = OP_XOR; req1_a = 8'hF0; req1_b = 8'hFF; req1_valid = 1'b1;
        @(negedge clk);
        total++;
        if ({req0_ready, req1_ready} !== 2'b10) begin
            bad++; $display("FAIL rr_first got=%b want=10", {req0_ready, req1_ready});
        end
        step();
        req0_valid = 1'b0;
        step();
        @(negedge clk);
        total++;
        if (rsp0_valid !== 1'b1 || rsp0_result !== 8'h00 || rsp0_flags !== 4'b1010) begin
            bad++; $display("FAIL rr_rsp0 got=%b/%h/%b want=1/00/1010", rsp0_valid, rsp0_result, rsp0_flags);
        end
        total++;
        if (req1_ready !== 1'b0 || rsp1_valid !== 1'b0) begin
            bad++; $display("FAIL rr_hold1 got=%b%b want=00", req1_ready, rsp1_valid);
        end
        step();
        @(negedge clk);
        total++;
        if ({req0_ready, req1_ready} !== 2'b01) begin
            bad++; $display("FAIL rr_second got=%b want=01", {req0_ready, req1_ready});
        end
        step();
        req1_valid = 1'b0;
        step();
        @(negedge clk);
        total++;
        if (rsp1_valid !== 1'b1 || rsp1_result !== 8'h0F || rsp1_flags !== 4'b0000) begin
            bad++; $display("FAIL rr_rsp1 got=%b/%h/%b want=1/0f/0000", rsp1_valid, rsp1_result, rsp1_flags);
        end
        total++;
        if (rsp0_valid !== 1'b0 || rsp0_result !== 8'h00) begin
            bad++; $display("FAIL rr_nonowner got=%b/%h want=0/00", rsp0_valid, rsp0_result);
        end
        step();
        req0_valid = 1'b1; req1_valid = 1'b1;
        @(negedge clk);
        total++;
        if ({req0_ready, req1_ready} !== 2'b10) begin
            bad++; $display("FAIL rr_alternate got=%b want=10", {req0_ready, req1_ready});
        end
        step();
        req0_valid = 1'b0;
        repeat (2) step();
        @(negedge clk);
        total++;
        if ({req0_ready, req1_ready} !== 2'b01) begin
            bad++; $display("FAIL rr_alternate2 got=%b want=01", {req0_ready, req1_ready});
        end
        step();
        req1_valid = 1'b0;
        repeat (2) step();
    endtask

    task automatic test_backpressure();
        apply_reset();
        rsp0_ready = 1'b0;
        req0_op = OP_ADD; req0_a = 8'h12; req0_b = 8'h34; req0_valid = 1'b1;
        req1_op = OP_AND; req1_a = 8'h3C; req1_b = 8'h0F; req1_valid = 1'b1;
        @(negedge clk);
        total++;
        if (req0_ready !== 1'b1) begin
            bad++; $display("FAIL bp_accept got=%b want=1", req0_ready);
        end
        step();
        req0_valid = 1'b0;
        repeat (2) step();
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            total++;
            if ({rsp0_valid, req1_ready, busy} !== 3'b101 || rsp0_result !== 8'h46) begin
                bad++; $display("FAIL bp_hold[%0d] v,rdy1,busy got=%b res=%h want=101 res=46", i, {rsp0_valid, req1_ready, busy}, rsp0_result);
            end
            step();
        end
        rsp0_ready = 1'b1;
        @(negedge clk);
        total++;
        if (req1_ready !== 1'b0) begin
            bad++; $display("FAIL bp_release_same got=%b want=0", req1_ready);
        end
        step();
        @(negedge clk);
        total++;
        if ({req1_ready, rsp0_valid, busy} !== 3'b100) begin
            bad++; $display("FAIL bp_next_accept got=%b want=100", {req1_ready, rsp0_valid, busy});
        end
        step();
        req1_valid = 1'b0;
        step();
        @(negedge clk);
        total++;
        if (rsp1_valid !== 1'b1 || rsp1_result !== 8'h0C || rsp0_result !== 8'h46) begin
            bad++; $display("FAIL bp_rsp1 got=%b/%h r0=%h want=1/0c r0=46", rsp1_valid, rsp1_result, rsp0_result);
        end
        step();
    endtask

    task automatic test_reset_exec();
        int seen = 0;
        apply_reset();
        req0_op = OP_ADD; req0_a = 8'h01; req0_b = 8'h01; req0_valid = 1'b1;
        step();
        req0_valid = 1'b0;
        rst_n = 1'b0;
        @(negedge clk);
        total++;
        if ({busy, rsp0_valid} !== 2'b00) begin
            bad++; $display("FAIL rstx_async got=%b want=00", {busy, rsp0_valid});
        end
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            @(negedge clk);
            if (rsp0_valid || rsp1_valid) seen++;
        end
        total++;
        if (seen != 0) begin
            bad++; $display("FAIL rstx_no_rsp got=%0d cycles with valid want=0", seen);
        end
        step();
        req0_op = OP_OR; req0_a = 8'h0A; req0_b = 8'h50; req0_valid = 1'b1;
        req1_op = OP_XOR; req1_a = 8'h11; req1_b = 8'h22; req1_valid = 1'b1;
        @(negedge clk);
        total++;
        if ({req0_ready, req1_ready} !== 2'b10) begin
            bad++; $display("FAIL rstx_grant got=%b want=10", {req0_ready, req1_ready});
        end
        step();
        req0_valid = 1'b0;
        step();
        @(negedge clk);
        total++;
        if (rsp0_result !== 8'h5A) begin
            bad++; $display("FAIL rstx_result got=%h want=5a", rsp0_result);
        end
        step();
        step();
        req1_valid = 1'b0;
        repeat (2) step();
    endtask

    task automatic test_fixed_priority();
        int g0 = 0;
        int g1 = 0;
        int v1 = 0;
        f_req0_op = OP_ADD; f_req0_a = 8'h7F; f_req0_b = 8'h01; f_req0_valid = 1'b1;
        f_req1_op = OP_XOR; f_req1_a = 8'hF0; f_req1_b = 8'hFF; f_req1_valid = 1'b1;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (f_req0_ready) g0++;
            if (f_req1_ready) g1++;
            if (f_rsp1_valid) v1++;
            step();
        end
        f_req0_valid = 1'b0; f_req1_valid = 1'b0;
        total++;
        if (g0 != 4) begin
            bad++; $display("FAIL fp_req0_grants got=%0d want=4", g0);
        end
        total++;
        if (g1 != 0 || v1 != 0) begin
            bad++; $display("FAIL fp_req1_starved got=%0d/%0d want=0/0", g1, v1);
        end
        total++;
        if (f_rsp0_result !== 8'h80 || f_rsp0_flags !== 4'b0101) begin
            bad++; $display("FAIL fp_result got=%h/%b want=80/0101", f_rsp0_result, f_rsp0_flags);
        end
        repeat (3) step();
    endtask

    initial begin
        test_reset();
        test_single();
        test_contention_rr();
        test_backpressure();
        test_reset_exec();
        test_fixed_priority();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
